// File: rtl/clken_scheduler.sv
// clken_scheduler: multi-channel clock-enable generator.
// Each channel divides the fabric clock by a run-time divisor D and emits a
// registered one-cycle `tick` every D cycles plus a square-wave `level` that
// toggles on every tick (period 2*D). Divisors are written over a
// valid/ready port; an update to a running channel is held pending and swapped
// in at the next period boundary so no period is ever shortened or stretched.
// Optional feature macro: CLKEN_SCHED_SYNC_EN adds a `sync_start` input that
// phase-aligns every enabled channel to the same edge.
module clken_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
`ifdef CLKEN_SCHED_SYNC_EN
    input  logic                                       sync_start,
`endif
    input  logic                                       cfg_valid,
    output logic                                       cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                           cfg_div,
    input  logic                                       cfg_en,
    output logic [NUM_CH-1:0]                          tick,
    output logic [NUM_CH-1:0]                          level,
    output logic [NUM_CH-1:0]                          active
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Per-channel state
    logic [CNT_W-1:0]  r_count    [NUM_CH];
    logic [CNT_W-1:0]  r_div_act  [NUM_CH];
    logic [CNT_W-1:0]  r_div_pend [NUM_CH];
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_tick;
    logic [NUM_CH-1:0] r_level;

    // Decoded write / timing helpers
    logic              w_in_range;
    logic              w_pend_sel;
    logic              w_accept;
    logic              w_sync;
    logic [CNT_W-1:0]  w_div_norm;
    logic [NUM_CH-1:0] w_wr_hit;
    logic [NUM_CH-1:0] w_wrap;

`ifdef CLKEN_SCHED_SYNC_EN
    assign w_sync = sync_start;
`else
    assign w_sync = 1'b0;
`endif

    // A zero divisor would never wrap; it behaves as divide-by-one.
    assign w_div_norm = (cfg_div == '0) ? CNT_W'(1) : cfg_div;

    // Writes aimed past the last channel are accepted and dropped.
    assign w_in_range = (32'(cfg_ch) < NUM_CH);

    // Pending flag of the addressed channel; out-of-range reads as clear.
    always_comb begin
        w_pend_sel = 1'b0;
        if (w_in_range) begin
            w_pend_sel = r_pend[cfg_ch];
        end
    end

    // A channel holding an unapplied divisor refuses further updates;
    // disables always go through so a consumer can always be stopped.
    assign cfg_ready = !w_pend_sel || !cfg_en;
    assign w_accept  = cfg_valid && cfg_ready;

    // One-hot decode of the channel written on this edge.
    always_comb begin
        w_wr_hit = '0;
        if (w_accept && w_in_range) begin
            w_wr_hit[cfg_ch] = 1'b1;
        end
    end

    // Period boundary: the counter has reached its last value for this period.
    always_comb begin
        w_wrap = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_wrap[c] = r_en[c] && (r_count[c] == (r_div_act[c] - CNT_W'(1)));
        end
    end

    // Per-channel counter, divisor swap, tick and level generation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_count[c]   <= '0;
                r_div_act[c] <= CNT_W'(DEFAULT_DIV);
            end
            r_pend  <= '0;
            r_en    <= '0;
            r_tick  <= '0;
            r_level <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_wr_hit[c] && !cfg_en) begin
                    // Disable: park the channel silent at phase zero.
                    r_en[c]    <= 1'b0;
                    r_pend[c]  <= 1'b0;
                    r_count[c] <= '0;
                    r_level[c] <= 1'b0;
                    r_tick[c]  <= 1'b0;
                end else if (w_wr_hit[c] && !r_en[c]) begin
                    // Start from idle: new divisor takes effect immediately.
                    r_en[c]      <= 1'b1;
                    r_pend[c]    <= 1'b0;
                    r_div_act[c] <= w_div_norm;
                    r_count[c]   <= '0;
                    r_level[c]   <= 1'b0;
                    r_tick[c]    <= 1'b0;
                end else if (w_wr_hit[c]) begin
                    // Update of a running channel: finish the current period
                    // with the old divisor. On a wrap edge the new value
                    // bypasses the pending register.
                    if (w_wrap[c]) begin
                        r_count[c]   <= '0;
                        r_tick[c]    <= 1'b1;
                        r_level[c]   <= ~r_level[c];
                        r_div_act[c] <= w_div_norm;
                        r_pend[c]    <= 1'b0;
                    end else begin
                        r_count[c] <= r_count[c] + CNT_W'(1);
                        r_tick[c]  <= 1'b0;
                        r_pend[c]  <= 1'b1;
                    end
                end else if (r_en[c]) begin
                    if (w_sync) begin
                        // Phase-align: restart the period, keep divisors.
                        r_count[c] <= '0;
                        r_level[c] <= 1'b0;
                        r_tick[c]  <= 1'b0;
                    end else if (w_wrap[c]) begin
                        r_count[c] <= '0;
                        r_tick[c]  <= 1'b1;
                        r_level[c] <= ~r_level[c];
                        if (r_pend[c]) begin
                            r_div_act[c] <= r_div_pend[c];
                            r_pend[c]    <= 1'b0;
                        end
                    end else begin
                        r_count[c] <= r_count[c] + CNT_W'(1);
                        r_tick[c]  <= 1'b0;
                    end
                end else begin
                    r_tick[c] <= 1'b0;
                end
            end
        end
    end

    // Capture a deferred divisor; only meaningful while r_pend is set.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_wr_hit[c] && cfg_en && r_en[c] && !w_wrap[c]) begin
                r_div_pend[c] <= w_div_norm;
            end
        end
    end

    assign tick   = r_tick;
    assign level  = r_level;
    assign active = r_en;

endmodule

// File: doc/clken_scheduler.md
# clken_scheduler

- Multi-channel, run-time-programmable clock-enable scheduler for the Connect4 design.
- Generates, from one fabric clock, per-channel single-cycle `tick` enables and divided square-wave `level` outputs for several consumers (display refresh, input debounce, drop animation, AI step).
- Division ratios are configured over a valid/ready write port. Ratio changes take effect glitch-free at the next period boundary.
- All downstream logic stays on one clock and uses `tick` as an enable; no derived clocks.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent channels (1–16).
- `CNT_W`, 32: counter and divisor width.
- `DEFAULT_DIV`, 2: divisor loaded into every channel at reset.

Ports:
- `clk` in 1: fabric clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: configuration write request.
- `cfg_ready` out 1: write can be accepted this cycle.
- `cfg_ch` in `$clog2(NUM_CH)` (min 1): target channel.
- `cfg_div` in `CNT_W`: half-period divisor D, in clk cycles.
- `cfg_en` in 1: 1 = enable/update the channel, 0 = disable it.
- `tick` out `NUM_CH`: one-cycle enable pulse per channel, registered.
- `level` out `NUM_CH`: toggles on every tick; period is 2·D clk cycles.
- `active` out `NUM_CH`: channel enabled.

## Operation
- Per-channel state: `count[CNT_W]`, `div_act`, `div_pend`, `pend` flag, `en`.
- Reset values:
  - `count` = 0, `div_act` = `DEFAULT_DIV`, `pend` = 0, `en` = 0.
  - `tick` = 0, `level` = 0, `active` = 0, `cfg_ready` = 1.
- Handshake:
  - A write is accepted on an edge where `cfg_valid && cfg_ready`.
  - `cfg_ready` is combinational: `!pend[cfg_ch] || !cfg_en`. Disable writes are always accepted.
  - `cfg_ch` ≥ `NUM_CH`: the write is accepted and ignored.
- Divisor rule: `cfg_div == 0` is treated as 1. Divisor is unsigned, full `CNT_W` width.
- Channel disabled, write with `cfg_en=1`:
  - `div_act` ← D, `count` ← 0, `level` ← 0, `en` ← 1.
- Channel enabled, write with `cfg_en=1`:
  - Normally sets `div_pend` ← D and `pend` ← 1.
  - If the same edge is a wrap edge, D bypasses into `div_act` at that wrap and `pend` stays 0.
- Write with `cfg_en=0`:
  - `en`, `pend` ← 0; `count` ← 0; `level` ← 0.
  - `tick` is forced 0 from the next cycle.
- Counting:
  - Enabled channel: each edge, if `count == div_act-1` (wrap), then `count` ← 0, `tick` ← 1, `level` ← ~`level`, and if `pend`: `div_act` ← `div_pend`, `pend` ← 0.
  - Otherwise `count` ← `count+1` and `tick` ← 0.
- Channels are fully independent. Only one channel is configured per cycle.
- `active` mirrors `en`.

## Timing
- Enable accepted at edge E0: first `tick` is high in the cycle after edge E0+D, i.e. latency D cycles.
- After that, `tick` repeats exactly every D cycles.
- D=1: `tick` is constantly high and `level` toggles every cycle (clk/2).
- Ratio update accepted mid-period: the current period completes with the old D. The next period uses the new D, with no shortened or stretched period.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). After release, channels stay idle until configured.
- Counter wrap with `div_act` = 2^`CNT_W`−1 has no overflow, because `count` never exceeds `div_act-1`.

## Configuration
- `CLKEN_SCHED_SYNC_EN`, defined: adds input port `sync_start` (1 bit).
  - On an edge with `sync_start=1`, every enabled channel sets `count` ← 0, `level` ← 0, `tick` ← 0, and keeps `div_act` and `pend`.
  - This phase-aligns all channels.
  - A config write on the same edge takes precedence for its channel.
- `CLKEN_SCHED_SYNC_EN`, undefined: the `sync_start` port is absent and channels free-run from their own enable edges.

## Test plan
- Reset, then enable ch0 with D=3 → `tick[0]` high one cycle every 3 cycles; first pulse 3 cycles after accept; `level[0]` period 6 cycles.
- Ch1 running D=4; write D=2 at count=1 → one more 4-cycle period, then 2-cycle periods. A second write while `pend` is set sees `cfg_ready=0` until the wrap.
- Write D=0 to ch2 → behaves as D=1: `tick[2]` constantly high, `level[2]` toggles every cycle.
- Ch0 D=5 running; disable at count=2 → `tick[0]`, `level[0]`, `active[0]` all 0 next cycle; re-enable with D=2 restarts from count 0.
- Assert `reset` asynchronously mid-period with all channels active → all outputs 0 before the next edge, `cfg_ready`=1, `div_act`=`DEFAULT_DIV`.
- With `CLKEN_SCHED_SYNC_EN`: ch0 D=3 and ch1 D=5 at arbitrary phases; pulse `sync_start` → both first ticks occur exactly 3 and 5 cycles later.
